serial_io_buffer: RTL and testbench
===================================

Name: serial_io_buffer

Overview:
- Parametrised, bidirectional byte-stream buffer between the processor's serial port and the external console or host.
- Successor to the single-byte serial_in/serial_out handshake. Adds independent TX and RX FIFOs of configurable width and depth, occupancy counters, sticky error flags, and an optional line-buffered TX mode that releases output only on complete lines.
- Sits between the processor serial pins and the top-level console/testbench printer.

Parameters:
- DATA_W, 8, byte width of both streams.
- DEPTH, 16, entries per FIFO. Power of two, >= 2.
- LINE_MODE, 0, 1 = TX released to host only when a full line or a full FIFO is present.
- NEWLINE, 8'h0A, line terminator compared against the low 8 bits of TX data.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_tx_data  in  DATA_W  byte written by processor.
- cpu_tx_wren  in  1  processor write strobe.
- cpu_tx_ready  out  1  TX FIFO not full.
- cpu_rx_data  out  DATA_W  head of RX FIFO (first-word-fall-through).
- cpu_rx_valid  out  1  RX FIFO not empty.
- cpu_rx_rden  in  1  processor pop strobe.
- host_tx_data  out  DATA_W  head of TX FIFO.
- host_tx_valid  out  1  TX byte offered to host.
- host_tx_ready  in  1  host accepts byte.
- host_rx_data  in  DATA_W  byte from host.
- host_rx_valid  in  1  host offers byte.
- host_rx_ready  out  1  RX FIFO not full.
- tx_count  out  $clog2(DEPTH)+1  TX occupancy.
- rx_count  out  $clog2(DEPTH)+1  RX occupancy.
- tx_overflow  out  1  sticky: write attempted while TX full.
- rx_underflow  out  1  sticky: pop attempted while RX empty.

Behaviour:
- Reset: synchronous, active-high. Clears pointers, counts, newline counter and sticky flags.
  - Reset outputs: cpu_tx_ready=1, host_rx_ready=1, cpu_rx_valid=0, host_tx_valid=0, counts=0, flags=0.
  - Data outputs are don't-care while the corresponding valid is 0.
  - Reset mid-transfer discards all buffered data; no partial line is emitted.
- Push acceptance uses occupancy at the start of the cycle:
  - TX push = cpu_tx_wren & !full.
  - RX push = host_rx_valid & !full.
  - Pop in the same cycle does not free space for that cycle's push.
- Pop:
  - TX pop = host_tx_valid & host_tx_ready.
  - RX pop = cpu_rx_rden & !empty.
- Latency: a byte pushed at edge N is visible at the FIFO head, with valid=1, in the cycle after edge N. A pop at edge N presents the next entry in the cycle after N.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Push and pop on an empty FIFO: push accepted, pop ignored. For RX this also sets rx_underflow.
- Counts update exactly as +push −pop. Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
- cpu_tx_wren while full: byte dropped, tx_overflow set (sticky until reset), FIFO contents unchanged.
- cpu_rx_rden while empty: rx_underflow set, no state change.
- Host side never overflows; host_rx_valid while host_rx_ready=0 is simply not accepted.
- LINE_MODE=0: host_tx_valid = !tx_empty.
- LINE_MODE=1:
  - A newline counter tracks NEWLINE bytes resident in TX: +1 on push of NEWLINE, −1 on pop of NEWLINE.
  - host_tx_valid = !tx_empty & (nl_count>0 | tx_full).
  - Bytes after the last resident NEWLINE are held until another NEWLINE arrives or the FIFO fills.
  - Once host_tx_valid is asserted, data is stable until accepted. host_tx_valid may deassert only after a pop.
- host_tx_data and cpu_rx_data are combinational reads of the head entry; all other outputs are registered or derived from registered state.

Test Plan:
- Reset, then idle 5 cycles -> cpu_tx_ready=1, host_rx_ready=1, both valids 0, counts 0, flags 0.
- LINE_MODE=0, host_tx_ready=1: write 'H','i' on consecutive cycles -> host sees 'H' then 'i' on the cycles after each write. tx_count peaks at 1.
- DEPTH=16, host_tx_ready=0: write 17 bytes 0x00..0x10 -> tx_count=16, cpu_tx_ready=0 after the 16th write, tx_overflow=1. Then drain -> 0x00..0x0F in order; 0x10 never appears.
- LINE_MODE=1: write "ab" -> host_tx_valid stays 0 for 10 cycles. Write 0x0A -> host receives 'a','b',0x0A back-to-back, then valid drops.
- RX: host sends 0x41,0x42 while the processor pops every cycle -> cpu_rx_data 0x41 then 0x42. A third pop sets rx_underflow=1. Same-cycle push/pop at count=1 keeps rx_count=1.
- Fill RX with 8 bytes, assert reset for 1 cycle mid-stream -> next cycle rx_count=0, cpu_rx_valid=0, flags cleared, host_rx_ready=1.

Source files
------------

// File: rtl/serial_io_buffer.sv
// Bidirectional byte-stream buffer between the processor serial port and the host
// console: independent TX/RX FIFOs, occupancy counters, sticky error flags, line-buffered TX.

module serial_io_buffer_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              wr_fire,
  output logic              rd_fire
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Acceptance is judged on start-of-cycle occupancy, so a pop never frees room
  // for a push in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = wr_req & ~full;
  assign rd_fire = rd_req & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the count alone says which entries are live.
  always_ff @(posedge clock) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end
  end
endmodule

module serial_io_buffer #(
  parameter int         DATA_W    = 8,
  parameter int         DEPTH     = 16,
  parameter bit         LINE_MODE = 1'b0,
  parameter logic [7:0] NEWLINE   = 8'h0A
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          cpu_tx_data,
  input  logic                       cpu_tx_wren,
  output logic                       cpu_tx_ready,
  output logic [DATA_W-1:0]          cpu_rx_data,
  output logic                       cpu_rx_valid,
  input  logic                       cpu_rx_rden,
  output logic [DATA_W-1:0]          host_tx_data,
  output logic                       host_tx_valid,
  input  logic                       host_tx_ready,
  input  logic [DATA_W-1:0]          host_rx_data,
  input  logic                       host_rx_valid,
  output logic                       host_rx_ready,
  output logic [$clog2(DEPTH):0]     tx_count,
  output logic [$clog2(DEPTH):0]     rx_count,
  output logic                       tx_overflow,
  output logic                       rx_underflow
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CMP_W = (DATA_W < 8) ? DATA_W : 8;

  logic tx_full, tx_empty, tx_wr_fire, tx_rd_fire;
  logic rx_full, rx_empty, rx_wr_fire, rx_rd_fire;
  logic nl_in, nl_out;
  logic [CNT_W-1:0] nl_count;

  serial_io_buffer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_req  (cpu_tx_wren),
    .wr_data (cpu_tx_data),
    .rd_req  (host_tx_valid & host_tx_ready),
    .rd_data (host_tx_data),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty),
    .wr_fire (tx_wr_fire),
    .rd_fire (tx_rd_fire)
  );

  serial_io_buffer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_req  (host_rx_valid),
    .wr_data (host_rx_data),
    .rd_req  (cpu_rx_rden),
    .rd_data (cpu_rx_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty),
    .wr_fire (rx_wr_fire),
    .rd_fire (rx_rd_fire)
  );

  assign cpu_tx_ready  = ~tx_full;
  assign host_rx_ready = ~rx_full;
  assign cpu_rx_valid  = ~rx_empty;

  // Resident-newline tally; in line mode a partial line is held back until it is
  // terminated or the FIFO fills. Neither condition can clear without a pop, so a
  // released byte stays offered until the host takes it.
  assign nl_in  = (cpu_tx_data[CMP_W-1:0]  == NEWLINE[CMP_W-1:0]);
  assign nl_out = (host_tx_data[CMP_W-1:0] == NEWLINE[CMP_W-1:0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      nl_count <= '0;
    end else begin
      nl_count <= nl_count + CNT_W'(tx_wr_fire & nl_in) - CNT_W'(tx_rd_fire & nl_out);
    end
  end

  assign host_tx_valid = ~tx_empty & (~LINE_MODE | (nl_count != '0) | tx_full);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= tx_overflow  | (cpu_tx_wren & tx_full);
      rx_underflow <= rx_underflow | (cpu_rx_rden & rx_empty);
    end
  end

  // rx_wr_fire / rx_rd_fire are consumed inside the FIFO; the top only needs full/empty.
  logic unused_fire;
  assign unused_fire = rx_wr_fire ^ rx_rd_fire;
endmodule

// File: tb/tb_serial_io_buffer.sv
// Self-checking bench for serial_io_buffer: scoreboard queues on both byte streams,
// a table of RX vectors, and directed sequences for overflow, line mode and reset.

module tb_serial_io_buffer;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Byte-stream instance (LINE_MODE=0)
  logic [DW-1:0] tx_data, rx_data, h_tx_data, h_rx_data;
  logic tx_wren, tx_ready, rx_valid, rx_rden, h_tx_valid, h_tx_ready, h_rx_valid, h_rx_ready;
  logic [CW-1:0] tx_count, rx_count;
  logic tx_ovf, rx_udf;

  // Line-buffered instance (LINE_MODE=1)
  logic [DW-1:0] lm_tx_data, lm_rx_data, lm_h_tx_data;
  logic lm_tx_wren, lm_tx_ready, lm_rx_valid, lm_h_tx_valid, lm_h_tx_ready, lm_h_rx_ready;
  logic [CW-1:0] lm_tx_count, lm_rx_count;
  logic lm_tx_ovf, lm_rx_udf;

  serial_io_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .LINE_MODE(1'b0), .NEWLINE(8'h0A)) dut (
    .clock(clock), .reset(reset),
    .cpu_tx_data(tx_data), .cpu_tx_wren(tx_wren), .cpu_tx_ready(tx_ready),
    .cpu_rx_data(rx_data), .cpu_rx_valid(rx_valid), .cpu_rx_rden(rx_rden),
    .host_tx_data(h_tx_data), .host_tx_valid(h_tx_valid), .host_tx_ready(h_tx_ready),
    .host_rx_data(h_rx_data), .host_rx_valid(h_rx_valid), .host_rx_ready(h_rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .tx_overflow(tx_ovf), .rx_underflow(rx_udf)
  );

  serial_io_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .LINE_MODE(1'b1), .NEWLINE(8'h0A)) dut_lm (
    .clock(clock), .reset(reset),
    .cpu_tx_data(lm_tx_data), .cpu_tx_wren(lm_tx_wren), .cpu_tx_ready(lm_tx_ready),
    .cpu_rx_data(lm_rx_data), .cpu_rx_valid(lm_rx_valid), .cpu_rx_rden(1'b0),
    .host_tx_data(lm_h_tx_data), .host_tx_valid(lm_h_tx_valid), .host_tx_ready(lm_h_tx_ready),
    .host_rx_data(8'h00), .host_rx_valid(1'b0), .host_rx_ready(lm_h_rx_ready),
    .tx_count(lm_tx_count), .rx_count(lm_rx_count),
    .tx_overflow(lm_tx_ovf), .rx_underflow(lm_rx_udf)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboards: expected bytes are queued when the bench drives an accepted write.
  logic [DW-1:0] tx_q[$], lm_q[$], rx_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (h_tx_valid && h_tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected_byte", {24'h0, h_tx_data}, 32'hFFFF_FFFF);
        else check("tx_stream", {24'h0, h_tx_data}, {24'h0, tx_q.pop_front()});
      end
      if (lm_h_tx_valid && lm_h_tx_ready) begin
        if (lm_q.size() == 0) check("lm_unexpected_byte", {24'h0, lm_h_tx_data}, 32'hFFFF_FFFF);
        else check("lm_stream", {24'h0, lm_h_tx_data}, {24'h0, lm_q.pop_front()});
      end
      if (rx_valid && rx_rden) begin
        if (rx_q.size() == 0) check("rx_unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
        else check("rx_stream", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic          hv;
    logic [DW-1:0] hd;
    logic          rden;
    logic [CW-1:0] exp_count;
    logic          exp_valid;
    logic          exp_udf;
  } rx_vec_t;

  rx_vec_t vecs[7];

  initial begin
    // Expected state after each edge, starting from an empty RX FIFO.
    vecs[0] = '{1'b1, 8'h41, 1'b0, 5'd1, 1'b1, 1'b0};  // push 0x41
    vecs[1] = '{1'b1, 8'h42, 1'b1, 5'd1, 1'b1, 1'b0};  // push+pop at count 1
    vecs[2] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0};  // pop 0x42
    vecs[3] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1};  // pop while empty
    vecs[4] = '{1'b1, 8'h43, 1'b1, 5'd1, 1'b1, 1'b1};  // push+pop on empty: push wins
    vecs[5] = '{1'b1, 8'h44, 1'b1, 5'd1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1};

    reset = 1'b1;
    tx_data = '0; tx_wren = 0; rx_rden = 0; h_tx_ready = 0; h_rx_data = '0; h_rx_valid = 0;
    lm_tx_data = '0; lm_tx_wren = 0; lm_h_tx_ready = 0;
    step(); step();
    reset = 1'b0;
    repeat (5) step();

    // Reset / idle state
    check("rst_tx_ready", tx_ready, 1);
    check("rst_h_rx_ready", h_rx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_h_tx_valid", h_tx_valid, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_ovf", tx_ovf, 0);
    check("rst_rx_udf", rx_udf, 0);
    check("rst_lm_h_tx_valid", lm_h_tx_valid, 0);

    // "Hi" pass-through with host always ready
    h_tx_ready = 1;
    tx_wren = 1; tx_data = "H"; tx_q.push_back("H");
    step();
    tx_data = "i"; tx_q.push_back("i");
    check("hi_valid_h", h_tx_valid, 1);
    check("hi_data_h", h_tx_data, "H");
    check("hi_count_h", tx_count, 1);
    step();
    tx_wren = 0;
    check("hi_valid_i", h_tx_valid, 1);
    check("hi_data_i", h_tx_data, "i");
    check("hi_count_i", tx_count, 1);
    step();
    check("hi_valid_end", h_tx_valid, 0);
    check("hi_count_end", tx_count, 0);

    // Overflow: 17 writes into a 16-deep FIFO with host stalled
    h_tx_ready = 0;
    for (int i = 0; i < 17; i++) begin
      tx_data = DW'(i); tx_wren = 1;
      if (i < DEPTH) tx_q.push_back(DW'(i));
      step();
      check("ovf_count", tx_count, (i + 1 < DEPTH) ? i + 1 : DEPTH);
      if (i == DEPTH - 1) begin
        check("ovf_ready_full", tx_ready, 0);
        check("ovf_flag_before", tx_ovf, 0);
      end
    end
    tx_wren = 0;
    check("ovf_flag", tx_ovf, 1);
    h_tx_ready = 1;
    for (int c = 0; c < 40 && tx_count != 0; c++) step();
    check("ovf_drained", tx_count, 0);
    check("ovf_flag_sticky", tx_ovf, 1);

    // Line mode: partial line held, newline releases it back-to-back
    lm_h_tx_ready = 1;
    lm_tx_wren = 1; lm_tx_data = "a"; lm_q.push_back("a");
    step();
    lm_tx_data = "b"; lm_q.push_back("b");
    step();
    lm_tx_wren = 0;
    for (int c = 0; c < 10; c++) begin
      check("lm_held", lm_h_tx_valid, 0);
      step();
    end
    check("lm_held_count", lm_tx_count, 2);
    lm_tx_wren = 1; lm_tx_data = 8'h0A; lm_q.push_back(8'h0A);
    step();
    lm_tx_wren = 0;
    check("lm_rel_a_valid", lm_h_tx_valid, 1);
    check("lm_rel_a", lm_h_tx_data, "a");
    step();
    check("lm_rel_b_valid", lm_h_tx_valid, 1);
    check("lm_rel_b", lm_h_tx_data, "b");
    step();
    check("lm_rel_nl_valid", lm_h_tx_valid, 1);
    check("lm_rel_nl", lm_h_tx_data, 8'h0A);
    step();
    check("lm_rel_done", lm_h_tx_valid, 0);

    // Line mode: a full FIFO releases one byte, then the partial line is held again
    lm_h_tx_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      lm_tx_wren = 1; lm_tx_data = 8'h30 + DW'(i); lm_q.push_back(8'h30 + DW'(i));
      step();
      if (i == DEPTH - 2) check("lm_full_minus1_held", lm_h_tx_valid, 0);
    end
    lm_tx_wren = 0;
    check("lm_full_valid", lm_h_tx_valid, 1);
    check("lm_full_head", lm_h_tx_data, 8'h30);
    lm_h_tx_ready = 1;
    step();
    check("lm_after_pop_held", lm_h_tx_valid, 0);
    check("lm_after_pop_count", lm_tx_count, DEPTH - 1);
    lm_tx_wren = 1; lm_tx_data = 8'h0A; lm_q.push_back(8'h0A);
    step();
    lm_tx_wren = 0;
    for (int c = 0; c < 40 && lm_tx_count != 0; c++) step();
    check("lm_drained", lm_tx_count, 0);
    check("lm_drained_valid", lm_h_tx_valid, 0);

    // RX vector table
    foreach (vecs[k]) begin
      h_rx_valid = vecs[k].hv; h_rx_data = vecs[k].hd; rx_rden = vecs[k].rden;
      if (vecs[k].hv) rx_q.push_back(vecs[k].hd);
      step();
      check($sformatf("rxvec%0d_count", k), rx_count, vecs[k].exp_count);
      check($sformatf("rxvec%0d_valid", k), rx_valid, vecs[k].exp_valid);
      check($sformatf("rxvec%0d_udf", k), rx_udf, vecs[k].exp_udf);
    end
    h_rx_valid = 0; rx_rden = 0;

    // RX fill to full: host is back-pressured, extra byte is not taken
    for (int i = 0; i < DEPTH; i++) begin
      h_rx_valid = 1; h_rx_data = 8'h50 + DW'(i); rx_q.push_back(8'h50 + DW'(i));
      step();
    end
    check("rx_full_count", rx_count, DEPTH);
    check("rx_full_ready", h_rx_ready, 0);
    h_rx_data = 8'h66;
    step();
    h_rx_valid = 0;
    check("rx_full_reject", rx_count, DEPTH);
    rx_rden = 1;
    for (int c = 0; c < 40 && rx_count != 0; c++) step();
    rx_rden = 0;
    check("rx_drained", rx_count, 0);

    // Reset mid-stream discards buffered RX data and clears flags
    for (int i = 0; i < 8; i++) begin
      h_rx_valid = 1; h_rx_data = 8'h70 + DW'(i); rx_q.push_back(8'h70 + DW'(i));
      step();
    end
    check("rx_fill8", rx_count, 8);
    h_rx_data = 8'h78;
    reset = 1;
    step();
    reset = 0; h_rx_valid = 0;
    rx_q.delete();
    check("mid_rst_rx_count", rx_count, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_udf", rx_udf, 0);
    check("mid_rst_tx_ovf", tx_ovf, 0);
    check("mid_rst_h_rx_ready", h_rx_ready, 1);
    step();
    check("post_rst_rx_valid", rx_valid, 0);

    check("tx_q_empty", tx_q.size(), 0);
    check("lm_q_empty", lm_q.size(), 0);
    check("rx_q_empty", rx_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
